// File: rtl/conv_pkg.sv
// Shared widths, accumulator sizing and signed data types for the ip_conv MAC stage.
package conv_pkg;

  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned IN_WIDTH    = 8;
  localparam int unsigned KERNEL_SIZE = 9;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Sized so a full window of extreme products cannot overflow.
  localparam int unsigned ACC_W = 2 * IN_WIDTH + clog2_f(KERNEL_SIZE);

  typedef logic signed [IN_WIDTH-1:0]   pixel_t;
  typedef logic signed [IN_WIDTH-1:0]   weight_t;
  typedef logic signed [2*IN_WIDTH-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]      acc_t;

endpackage

// File: rtl/conv_mac_mul.sv
// Registered signed pixel*weight multiplier with product-valid flag and synchronous flush.
module conv_mac_mul #(
  parameter int unsigned IN_WIDTH = conv_pkg::IN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ivalid,
  input  logic [IN_WIDTH-1:0]   ipixel,
  input  logic [IN_WIDTH-1:0]   iweight,
  input  logic                  iclear,
  output logic                  pvalid,
  output logic [2*IN_WIDTH-1:0] prod
);
  import conv_pkg::*;

  logic signed [2*IN_WIDTH-1:0] pix_ext;
  logic signed [2*IN_WIDTH-1:0] wgt_ext;
  logic                         accept;

  always_comb begin
    pix_ext = {{IN_WIDTH{ipixel[IN_WIDTH-1]}}, ipixel};
    wgt_ext = {{IN_WIDTH{iweight[IN_WIDTH-1]}}, iweight};
    accept  = ivalid && !iclear;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pvalid <= 1'b0;
      prod   <= '0;
    end else begin
      pvalid <= accept;
      if (accept) begin
        prod <= pix_ext * wgt_ext;
      end
    end
  end

endmodule

// File: rtl/conv_mac.sv
// Windowed multiply-accumulate: KERNEL_SIZE products per window, one ovalid pulse per result.
// Define CONV_MAC_SAT_EN to saturate the result instead of wrapping it.
module conv_mac #(
  parameter int unsigned DATA_WIDTH  = conv_pkg::DATA_WIDTH,
  parameter int unsigned IN_WIDTH    = conv_pkg::IN_WIDTH,
  parameter int unsigned KERNEL_SIZE = conv_pkg::KERNEL_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ivalid,
  input  logic [IN_WIDTH-1:0]   ipixel,
  input  logic [IN_WIDTH-1:0]   iweight,
  input  logic                  iclear,
  output logic                  ovalid,
  output logic [DATA_WIDTH-1:0] ovalue
);
  import conv_pkg::*;

  localparam int unsigned ACC_W = 2 * IN_WIDTH + clog2_f(KERNEL_SIZE);
  localparam int unsigned CNT_W = (clog2_f(KERNEL_SIZE) > 0) ? clog2_f(KERNEL_SIZE) : 1;

  logic                    pvalid;
  logic [2*IN_WIDTH-1:0]   prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0]        count;
  logic                    last;
  logic                    done_q;
  logic [DATA_WIDTH-1:0]   conv_val;

  conv_mac_mul #(.IN_WIDTH(IN_WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .ivalid (ivalid),
    .ipixel (ipixel),
    .iweight(iweight),
    .iclear (iclear),
    .pvalid (pvalid),
    .prod   (prod)
  );

  always_comb begin
    prod_ext = ACC_W'($signed(prod));
    acc_sum  = (count == '0) ? prod_ext : acc + prod_ext;
    last     = (count == CNT_W'(KERNEL_SIZE - 1));
`ifdef CONV_MAC_SAT_EN
    // In range only when every bit above the result sign bit matches it.
    if ((acc[ACC_W-1:DATA_WIDTH-1] == '0) || (acc[ACC_W-1:DATA_WIDTH-1] == '1)) begin
      conv_val = acc[DATA_WIDTH-1:0];
    end else if (acc[ACC_W-1]) begin
      conv_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      conv_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`else
    conv_val = acc[DATA_WIDTH-1:0];
`endif
  end

  // A final term already in stage 2 completes even under iclear, so its scheduled
  // result still fires; acc then holds the final sum until the next window's term 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      count  <= '0;
      done_q <= 1'b0;
      ovalid <= 1'b0;
      ovalue <= '0;
    end else begin
      ovalid <= done_q;
      if (done_q) begin
        ovalue <= conv_val;
      end
      if (pvalid && last) begin
        acc    <= acc_sum;
        count  <= '0;
        done_q <= 1'b1;
      end else begin
        done_q <= 1'b0;
        if (iclear) begin
          acc   <= '0;
          count <= '0;
        end else if (pvalid) begin
          acc   <= acc_sum;
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_mac.sv
// Directed bench for conv_mac: 3x3 instance for window behaviour, 1-term instance for streaming.
module tb_conv_mac;

  logic        clk;
  logic        rst;
  logic        ivalid_a, iclear_a, ovalid_a;
  logic [7:0]  ipixel_a, iweight_a;
  logic [15:0] ovalue_a;
  logic        ivalid_b, iclear_b, ovalid_b;
  logic [7:0]  ipixel_b, iweight_b;
  logic [15:0] ovalue_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pv[$];
  int pc[$];

  conv_mac #(.DATA_WIDTH(16), .IN_WIDTH(8), .KERNEL_SIZE(9)) dut_a (
    .clk(clk), .rst(rst), .ivalid(ivalid_a), .ipixel(ipixel_a), .iweight(iweight_a),
    .iclear(iclear_a), .ovalid(ovalid_a), .ovalue(ovalue_a)
  );

  conv_mac #(.DATA_WIDTH(16), .IN_WIDTH(8), .KERNEL_SIZE(1)) dut_b (
    .clk(clk), .rst(rst), .ivalid(ivalid_b), .ipixel(ipixel_b), .iweight(iweight_b),
    .iclear(iclear_b), .ovalid(ovalid_b), .ovalue(ovalue_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && ovalid_a) begin
      pv.push_back(int'($signed(ovalue_a)));
      pc.push_back(cyc);
    end
  end

  typedef struct {
    int p;
    int w;
    int n;
    int gap;
    int expv;
  } vec_t;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic beat(input int p, input int w, input bit clr);
    @(negedge clk);
    ivalid_a  = 1'b1;
    ipixel_a  = 8'(p);
    iweight_a = 8'(w);
    iclear_a  = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ivalid_a = 1'b0;
      iclear_a = 1'b0;
    end
  endtask

  task automatic run_window(input string name, input int p, input int w, input int n,
                            input int gap, input int expv);
    int base;
    int last_edge;
    base = pv.size();
    last_edge = 0;
    for (int i = 0; i < n; i++) begin
      if (gap > 0) idle($urandom_range(gap, 0));
      beat(p, w, 1'b0);
      last_edge = cyc + 1;
    end
    idle(5);
    chk({name, " pulses"}, pv.size() - base, 1);
    if (pv.size() == base + 1) begin
      chk({name, " value"}, pv[base], expv);
      if (gap == 0) chk({name, " latency"}, pc[base], last_edge + 2);
    end
  endtask

  vec_t tbl[4];

  initial begin
    int base;
    int ends[3];

    rst = 1'b1;
    ivalid_a = 1'b0; iclear_a = 1'b0; ipixel_a = '0; iweight_a = '0;
    ivalid_b = 1'b0; iclear_b = 1'b0; ipixel_b = '0; iweight_b = '0;

    tbl[0] = '{p: 3,    w: 2,    n: 9, gap: 0, expv: 54};
`ifdef CONV_MAC_SAT_EN
    tbl[1] = '{p: -128, w: -128, n: 9, gap: 0, expv: 32767};
    tbl[2] = '{p: -128, w: 127,  n: 9, gap: 0, expv: -32768};
`else
    tbl[1] = '{p: -128, w: -128, n: 9, gap: 0, expv: 16384};
    tbl[2] = '{p: -128, w: 127,  n: 9, gap: 0, expv: -15232};
`endif
    tbl[3] = '{p: 3,    w: 2,    n: 9, gap: 5, expv: 54};

    repeat (3) @(negedge clk);
    chk("reset ovalid_a", int'(ovalid_a), 0);
    chk("reset ovalue_a", int'(ovalue_a), 0);
    chk("reset ovalid_b", int'(ovalid_b), 0);
    chk("reset ovalue_b", int'(ovalue_b), 0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 4; i++) begin
      run_window($sformatf("window[%0d]", i), tbl[i].p, tbl[i].w, tbl[i].n, tbl[i].gap,
                 tbl[i].expv);
    end

    // Three back-to-back windows with no idle cycle between them.
    base = pv.size();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 9; i++) beat(k + 1, 1, 1'b0);
      ends[k] = cyc + 1;
    end
    idle(5);
    chk("b2b pulses", pv.size() - base, 3);
    if (pv.size() == base + 3) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("b2b[%0d] value", k), pv[base + k], 9 * (k + 1));
        chk($sformatf("b2b[%0d] latency", k), pc[base + k], ends[k] + 2);
      end
    end

    // Abort on beat 5: no result, previous value held, next window starts clean.
    base = pv.size();
    for (int i = 0; i < 4; i++) beat(1, 1, 1'b0);
    beat(1, 1, 1'b1);
    idle(8);
    chk("clear pulses", pv.size() - base, 0);
    chk("clear hold ovalue", int'($signed(ovalue_a)), 27);
    run_window("after clear", 1, 1, 9, 0, 9);

    // Asynchronous reset mid-window.
    for (int i = 0; i < 4; i++) beat(5, 5, 1'b0);
    idle(2);
    #1 rst = 1'b1;
    #1;
    chk("async rst ovalid", int'(ovalid_a), 0);
    chk("async rst ovalue", int'(ovalue_a), 0);
    #1 rst = 1'b0;
    run_window("after rst", 2, 2, 9, 0, 36);

    // Single-term kernel: a result every cycle once the pipe fills.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) chk("k1 latency gap", int'(ovalid_b), 0);
      if (i >= 3) begin
        chk($sformatf("k1 ovalid[%0d]", i), int'(ovalid_b), 1);
        chk($sformatf("k1 ovalue[%0d]", i), int'($signed(ovalue_b)), -35);
      end
      ivalid_b  = 1'b1;
      ipixel_b  = 8'(-5);
      iweight_b = 8'(7);
    end
    @(negedge clk);
    ivalid_b = 1'b0;
    repeat (4) @(negedge clk);
    chk("k1 idle ovalid", int'(ovalid_b), 0);
    chk("k1 idle hold", int'($signed(ovalue_b)), -35);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
